// File: rtl/dla_pkg.sv
`default_nettype none
// ============================================================================
// Module : dla_pkg
// Brief  : Shared types and constants for the DLA output post-processing path.
// Rev    : 1.0  initial release
// ============================================================================
package dla_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pp_state_t;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    // Bit positions of the per-tile enables in the controller's flags word
    localparam int FLAG_RELU = 0;
    localparam int FLAG_BIAS = 3;

endpackage
`default_nettype wire

// File: rtl/requant_pipe.sv
`default_nettype none
// ============================================================================
// Module : requant_pipe
// Brief  : Three-stage bias-add / scale / round-saturate-ReLU pipeline to int8.
// Rev    : 1.0  initial release
// ============================================================================
module requant_pipe
    import dla_pkg::*;
#(
    parameter int QSHIFT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_psum,
    input  logic [31:0] i_bias,
    input  logic        i_bias_en,
    input  logic        i_relu_en,
    input  logic [7:0]  i_scale,
    output logic        o_valid,
    output logic [7:0]  o_byte
);

    localparam logic signed [41:0] c_round = 42'sd1 <<< (QSHIFT - 1);
    localparam logic signed [41:0] c_max   = 42'(INT8_MAX);
    localparam logic signed [41:0] c_min   = 42'(INT8_MIN);

    logic               r_s1_valid;
    logic               r_s2_valid;
    logic               r_s3_valid;
    logic signed [32:0] r_sum;
    logic signed [41:0] r_prod;
    logic [7:0]         r_byte;

    logic signed [32:0] w_psum_x;
    logic signed [32:0] w_bias_x;
    logic signed [41:0] w_sum_x;
    logic signed [41:0] w_scale_x;
    logic signed [41:0] w_rounded;
    logic signed [41:0] w_shifted;
    logic [7:0]         w_sat;

    assign w_psum_x  = 33'($signed(i_psum));
    assign w_bias_x  = i_bias_en ? 33'($signed(i_bias)) : 33'sd0;
    assign w_sum_x   = 42'(r_sum);
    assign w_scale_x = 42'($signed({1'b0, i_scale}));
    assign w_rounded = r_prod + c_round;
    assign w_shifted = w_rounded >>> QSHIFT;

    // ReLU takes priority, then clamp into the int8 range
    always_comb begin
        w_sat = w_shifted[7:0];
        if (i_relu_en && w_shifted[41]) begin
            w_sat = 8'h00;
        end else if (w_shifted > c_max) begin
            w_sat = 8'(INT8_MAX);
        end else if (w_shifted < c_min) begin
            w_sat = 8'(INT8_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_sum      <= '0;
            r_prod     <= '0;
            r_byte     <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            r_sum      <= w_psum_x + w_bias_x;
            r_prod     <= w_sum_x * w_scale_x;
            r_byte     <= w_sat;
        end
    end

    assign o_valid = r_s3_valid;
    assign o_byte  = r_byte;

endmodule
`default_nettype wire

// File: rtl/opsum_postproc_writer.sv
`default_nettype none
// ============================================================================
// Module : opsum_postproc_writer
// Brief  : Requantizes OPSUM FIFO partial sums to int8 and packs them into GLB.
// Rev    : 1.0  initial release
// ============================================================================
module opsum_postproc_writer
    import dla_pkg::*;
#(
    parameter int QSHIFT = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [CNT_W-1:0] num_out_i,
    input  logic [31:0]      bias_i,
    input  logic             bias_en_i,
    input  logic             relu_en_i,
    input  logic [7:0]       quant_scale_i,
    input  logic             psum_valid_i,
    input  logic [31:0]      psum_data_i,
    output logic             psum_ready_o,
    output logic [31:0]      glb_addr_o,
    output logic [31:0]      glb_write_data_o,
    output logic [3:0]       glb_web_o,
    output logic             busy_o,
    output logic             done_o
);

    pp_state_t        r_state;
    logic [CNT_W-1:0] r_num_out;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] r_out_idx;
    logic [7:0]       r_scale;
    logic             r_bias_en;
    logic             r_relu_en;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_word_addr;
    logic [31:0]      r_pack_data;
    logic [3:0]       r_pack_mask;
    logic             r_last_wr;
    logic [31:0]      r_glb_addr;
    logic [31:0]      r_glb_data;
    logic [3:0]       r_glb_web;

    logic             w_start;
    logic             w_fire;
    logic             w_out_valid;
    logic [7:0]       w_out_byte;
    logic [1:0]       w_lane;
    logic             w_final_elem;
    logic             w_word_full;
    logic [31:0]      w_merged_data;
    logic [3:0]       w_merged_mask;

    assign w_start      = (r_state == IDLE) && start_i;
    assign psum_ready_o = (r_state == RUN) && (r_acc_cnt < r_num_out);
    assign w_fire       = psum_valid_i && psum_ready_o;

    requant_pipe #(
        .QSHIFT (QSHIFT)
    ) u_requant_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (w_fire),
        .i_psum    (psum_data_i),
        .i_bias    (bias_i),
        .i_bias_en (r_bias_en),
        .i_relu_en (r_relu_en),
        .i_scale   (r_scale),
        .o_valid   (w_out_valid),
        .o_byte    (w_out_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_num_out <= '0;
            r_acc_cnt <= '0;
            r_scale   <= '0;
            r_bias_en <= 1'b0;
            r_relu_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_num_out <= num_out_i;
                        r_scale   <= quant_scale_i;
                        r_bias_en <= bias_en_i;
                        r_relu_en <= relu_en_i;
                        r_acc_cnt <= '0;
                        r_busy    <= 1'b1;
                        if (num_out_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_fire) begin
                        r_acc_cnt <= r_acc_cnt + 1'b1;
                        if (r_acc_cnt == r_num_out - 1'b1) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The final word is on the GLB ports this cycle
                    if (r_last_wr) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_lane       = r_out_idx[1:0];
    assign w_final_elem = (r_out_idx == r_num_out - 1'b1);
    assign w_word_full  = w_out_valid && ((w_lane == 2'd3) || w_final_elem);

    always_comb begin
        w_merged_data                = r_pack_data;
        w_merged_mask                = r_pack_mask;
        w_merged_data[8*w_lane +: 8] = w_out_byte;
        w_merged_mask[w_lane]        = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_idx   <= '0;
            r_word_addr <= '0;
            r_pack_data <= '0;
            r_pack_mask <= '0;
            r_last_wr   <= 1'b0;
            r_glb_addr  <= '0;
            r_glb_data  <= '0;
            r_glb_web   <= 4'hF;
        end else begin
            r_glb_web <= 4'hF;
            r_last_wr <= 1'b0;
            if (w_start) begin
                r_out_idx   <= '0;
                r_word_addr <= base_addr_i & ~32'd3;
                r_pack_data <= '0;
                r_pack_mask <= '0;
            end else if (w_out_valid) begin
                r_out_idx <= r_out_idx + 1'b1;
                if (w_word_full) begin
                    r_glb_data  <= w_merged_data;
                    r_glb_web   <= ~w_merged_mask;
                    r_glb_addr  <= r_word_addr;
                    r_word_addr <= r_word_addr + 32'd4;
                    r_pack_data <= '0;
                    r_pack_mask <= '0;
                    r_last_wr   <= w_final_elem;
                end else begin
                    r_pack_data <= w_merged_data;
                    r_pack_mask <= w_merged_mask;
                end
            end
        end
    end

    assign glb_addr_o       = r_glb_addr;
    assign glb_write_data_o = r_glb_data;
    assign glb_web_o        = r_glb_web;
    assign busy_o           = r_busy;
    assign done_o           = r_done;

endmodule
`default_nettype wire
